// File: rtl/control2if_pkg.sv
// Shared types and constants for the instruction-fetch stage and its skid buffer.
package control2if_pkg;

  localparam int AW_DEF = 12;
  localparam int IW_DEF = 24;

  // Encoding shown on instr_out whenever no real instruction has been fetched yet.
  localparam logic [IW_DEF-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [AW_DEF-1:0] pc;
    logic [IW_DEF-1:0] instr;
  } if_beat_t;

endpackage

// File: rtl/fetchbuf2if.sv
// DEPTH-entry FIFO of fetched {pc, instr} beats; clear empties it in one cycle.
module fetchbuf2if
  import control2if_pkg::*;
#(
  parameter type T     = if_beat_t,
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output T              head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == FULL_LVL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/control2if.sv
// IF stage: pairs each PC with its memory word, skid-buffers beats under ID stalls
// and drives a registered {enable, pc, instr} beat, with flush and wrong-path squash.
module control2if
  import control2if_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int IW    = IW_DEF,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_in,
  input  logic [AW-1:0] pc_in,
  input  logic [IW-1:0] mem_data,
  input  logic          stall_in,
  input  logic          flush_in,
  output logic          enable_out,
  output logic [AW-1:0] pc_out,
  output logic [IW-1:0] instr_out,
  output logic          stall_out,
  output logic          ovf_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] HI_LVL  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] MID_LVL = CW'(DEPTH - 2);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } beat_t;

  logic          en_q, en_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          squash_q, squash_d;
  logic          ovf_q, ovf_d;

  beat_t         in_beat, head;
  logic [CW-1:0] buf_count;
  logic          buf_full, buf_empty;
  logic          advance, accepted, bypass, pop, push_req, push, ovf_hit;

  assign in_beat  = '{pc: pc_in, instr: mem_data};
  assign advance  = ~stall_in | ~en_q;
  assign accepted = enable_in & ~flush_in & ~squash_q;

  // Buffered beats always leave before a newly arrived one so order is kept.
  assign pop      = advance & ~buf_empty & ~flush_in;
  assign bypass   = advance & buf_empty & accepted;
  assign push_req = accepted & ~bypass;
  assign push     = push_req & (~buf_full | pop);
  assign ovf_hit  = push_req & buf_full & ~pop;

  // Raise early enough that the fetch IA already has in flight still finds a slot.
  assign stall_out = (buf_count >= HI_LVL) |
                     ((buf_count == MID_LVL) & ~advance & accepted);

  fetchbuf2if #(
    .T     (beat_t),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (in_beat),
    .pop_i   (pop),
    .clear_i (flush_in),
    .head_o  (head),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  always_comb begin
    en_d     = en_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    squash_d = squash_q;
    ovf_d    = ovf_q | ovf_hit;
    if (flush_in) begin
      en_d     = 1'b0;
      squash_d = 1'b1;
    end else begin
      if (advance) begin
        if (!buf_empty) begin
          en_d    = 1'b1;
          pc_d    = head.pc;
          instr_d = head.instr;
        end else if (accepted) begin
          en_d    = 1'b1;
          pc_d    = pc_in;
          instr_d = mem_data;
        end else begin
          en_d    = 1'b0;
        end
      end
      // Squash only disarms on the wrong-path beat it was waiting for.
      if (squash_q && enable_in) squash_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      pc_q     <= '0;
      instr_q  <= IW'(NOP_INSTR);
      squash_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      squash_q <= squash_d;
      ovf_q    <= ovf_d;
    end
  end

  assign enable_out = en_q;
  assign pc_out     = pc_q;
  assign instr_out  = instr_q;
  assign ovf_err    = ovf_q;

endmodule
